// File: rtl/axis_arb_pkg.sv
// Shared arbiter definitions: FSM state encoding and the round-robin winner search.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  // Returns the first requester strictly after 'last', wrapping at n (n <= 8).
  // Wrap is an explicit compare so non-power-of-two n never selects an unused index.
  function automatic logic [2:0] next_rr(input logic [2:0] last, input logic [7:0] req,
                                         input int n);
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    idx   = last;
    win   = last;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < n) begin
        idx = (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
        if (req[idx] && !found) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry skid buffer: registered output stage plus one skid entry, FIFO order.
module axis_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             push;

  // Ready is a pure register output: an entry is free whenever the skid slot is empty.
  assign in_ready = ~skid_valid;
  assign push     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= push;
        if (push) out_data <= in_data;
      end
    end else if (push) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI4-Stream sources into one
// registered master port; a grant is held from first beat through TLAST.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC            = 4,
  parameter int C_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                  M_AXIS_ACLK,
  input  logic                                  M_AXIS_ARESETN,
  input  logic [NUM_SRC-1:0]                    S_AXIS_TVALID,
  input  logic [NUM_SRC*C_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC*C_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic [NUM_SRC-1:0]                    S_AXIS_TLAST,
  output logic [NUM_SRC-1:0]                    S_AXIS_TREADY,
  output logic                                  M_AXIS_TVALID,
  output logic [C_AXIS_TDATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]       M_AXIS_TSTRB,
  output logic                                  M_AXIS_TLAST,
  input  logic                                  M_AXIS_TREADY,
  output logic [$clog2(NUM_SRC)-1:0]            GRANT_ID,
  output logic                                  BUSY,
  output arb_state_e                            dbg_state
);

  localparam int W   = C_AXIS_TDATA_WIDTH;
  localparam int SW  = W / 8;
  localparam int IW  = $clog2(NUM_SRC);
  localparam int SLW = 1 + SW + W;

  arb_state_e      state;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   last_grant;
  logic            sel_valid;
  logic            sel_last;
  logic [SW-1:0]   sel_strb;
  logic [W-1:0]    sel_data;
  logic            slice_in_valid;
  logic            slice_ready;
  logic [SLW-1:0]  slice_out;
  logic            beat_done;

  always_comb begin
    sel_valid = S_AXIS_TVALID[grant];
    sel_last  = S_AXIS_TLAST[grant];
    sel_strb  = S_AXIS_TSTRB[grant*SW +: SW];
    sel_data  = S_AXIS_TDATA[grant*W +: W];
  end

  // Handshakes: a beat moves on any interface only in a cycle where both VALID and
  // READY are high at the rising edge; VALID never waits on READY, and the master
  // side holds VALID and payload steady until accepted.
  always_comb begin
    S_AXIS_TREADY = '0;
    if (state == ARB_XFER) S_AXIS_TREADY[grant] = slice_ready;
  end

  assign slice_in_valid = (state == ARB_XFER) && sel_valid;
  assign beat_done      = slice_in_valid && slice_ready && sel_last;

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_SRC - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|S_AXIS_TVALID) begin
            grant <= IW'(next_rr(3'(last_grant), 8'(S_AXIS_TVALID), NUM_SRC));
            state <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (beat_done) begin
            last_grant <= grant;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  axis_reg_slice #(.WIDTH(SLW)) u_slice (
    .clk      (M_AXIS_ACLK),
    .rst_n    (M_AXIS_ARESETN),
    .in_valid (slice_in_valid),
    .in_ready (slice_ready),
    .in_data  ({sel_last, sel_strb, sel_data}),
    .out_valid(M_AXIS_TVALID),
    .out_ready(M_AXIS_TREADY),
    .out_data (slice_out)
  );

  assign {M_AXIS_TLAST, M_AXIS_TSTRB, M_AXIS_TDATA} = slice_out;
  assign GRANT_ID  = grant;
  assign BUSY      = (state == ARB_XFER);
  assign dbg_state = state;

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Packet-level round-robin arbiter sharing one AXI4-Stream master port between `NUM_SRC` stream generators of the same family as the team's AXIS master sources. A grant is held from a packet's first beat through the beat carrying TLAST, so packets are never interleaved. The output passes through a two-entry register slice, so `M_AXIS_TREADY` has no combinational path to any `S_AXIS_TREADY`. It sits between the per-channel stream sources and the single downstream DMA/stream sink.

## Interface
- `NUM_SRC`, default 4: number of requesting slave streams, 2..8.
- `C_AXIS_TDATA_WIDTH`, default 32: data width in bits, a multiple of 8.
- `M_AXIS_ACLK` in, 1: the only clock; everything is rising-edge.
- `M_AXIS_ARESETN` in, 1: asynchronous, active-low reset.
- `S_AXIS_TVALID` in, `NUM_SRC`: per-source valid.
- `S_AXIS_TDATA` in, `NUM_SRC*C_AXIS_TDATA_WIDTH`: source i occupies slice [i*W +: W].
- `S_AXIS_TSTRB` in, `NUM_SRC*C_AXIS_TDATA_WIDTH/8`: per-source strobes, same packing.
- `S_AXIS_TLAST` in, `NUM_SRC`: per-source end of packet.
- `S_AXIS_TREADY` out, `NUM_SRC`: at most one bit high per cycle.
- `M_AXIS_TVALID`, `M_AXIS_TDATA`, `M_AXIS_TSTRB`, `M_AXIS_TLAST` out: registered merged stream.
- `M_AXIS_TREADY` in, 1: downstream ready.
- `GRANT_ID` out, `$clog2(NUM_SRC)`: currently or last granted source.
- `BUSY` out, 1: high while in XFER.

## Operation
- FSM states are IDLE and XFER.
- IDLE
  - All `S_AXIS_TREADY` are low.
  - If any `S_AXIS_TVALID` is high, pick the winner: the first valid source scanning upward from `last_grant+1`, wrapping modulo `NUM_SRC`.
  - Register the winner in `grant` and go to XFER.
- XFER
  - `S_AXIS_TREADY[grant] = slice_ready`; all other ready bits are 0.
  - The granted source's TDATA/TSTRB/TLAST feed the slice.
  - A beat transfers into the slice when `S_AXIS_TVALID[grant] && slice_ready`.
  - A transferred beat with TLAST=1 sets `last_grant <= grant` and returns the FSM to IDLE.
- The grant is held when the granted source drops TVALID mid-packet; there is no timeout.
- Valid changes on non-granted sources are ignored until IDLE.
- Register slice: two-entry skid buffer.
  - `slice_ready` is registered and high when at least one entry is free.
  - Output order is FIFO. No beat is lost or duplicated under any TREADY pattern.
- Any `S_AXIS_TSTRB` value is forwarded unchanged. The block never generates TSTRB.
- A source index width of `$clog2(NUM_SRC)` must handle non-power-of-two `NUM_SRC`; wrap is an explicit compare, not truncation.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream) clears everything immediately:
  - State goes to IDLE.
  - `last_grant = NUM_SRC-1`, so source 0 has first priority after reset.
  - `GRANT_ID = 0`, `BUSY = 0`.
  - All `S_AXIS_TREADY = 0`, `M_AXIS_TVALID = 0`, `M_AXIS_TLAST = 0`, `M_AXIS_TDATA = 0`, `M_AXIS_TSTRB = 0`.
  - The slice is emptied.
- Reset mid-packet: the partial packet is discarded and no TLAST is emitted. The sources must restart their packets.
- Arbitration latency: valid seen in IDLE at cycle t gives `BUSY = 1` and `S_AXIS_TREADY` high at t+1, when the slice is ready.
- Data latency: a beat accepted from a source at cycle t appears on `M_AXIS_*` at t+1 at the earliest.
- Throughput: one beat per cycle inside a packet while `M_AXIS_TREADY` stays high.
- Between packets there is exactly one IDLE bubble cycle on the slave side. The TLAST beat and the next arbitration never occur in the same cycle.
- `M_AXIS_TVALID`, once high, stays high with stable data until `M_AXIS_TREADY` is seen (AXIS rule).

## Structure
- Shared package `axis_arb_pkg` holds:
  - the FSM state typedef (`ARB_IDLE = 1'b0`, `ARB_XFER = 1'b1`);
  - the `next_rr(last, req)` round-robin function, reused by the other arbiters.
- Sub-module `axis_reg_slice`: a generic two-entry skid buffer with parameter `WIDTH`, carrying {TLAST, TSTRB, TDATA}. It is instantiated once.

## Test plan
- Source 0 sends a 3-word packet (1, 2, 3, TLAST on 3) with `M_AXIS_TREADY = 1`. Required: `S_AXIS_TREADY[0]` rises one cycle after TVALID; output is 1, 2, 3 on consecutive cycles with TLAST only on 3; `BUSY` falls after the last beat.
- Sources 0 and 1 both valid at the same cycle, each with a 2-word packet. Required: source 0 is served first, then source 1 after one bubble, with `GRANT_ID` 0 then 1 and no interleaving.
- All 4 sources continuously valid for 8 packets. Required: grant order 0, 1, 2, 3, 0, 1, 2, 3.
- `M_AXIS_TREADY` toggles 1, 0, 0, 1 during a 5-word packet. Required: all 5 words arrive in order with no loss or duplicates; `M_AXIS_TDATA` is stable while stalled; the slave TREADY drops within one cycle after the slice fills.
- Granted source 2 deasserts TVALID for 3 cycles mid-packet while source 3 is valid. Required: the grant stays on 2 and source 3 waits until after 2's TLAST.
- Reset is asserted on word 2 of a 4-word packet. Required: `M_AXIS_TVALID` is 0 immediately; after release source 0 has priority again and the output carries no stale words.
